// File: rtl/seg_scan_decoder_if.sv
// ============================================================================
// Module   : seg_scan_decoder_if
// Brief    : Multiplexed seven-segment bus (segments + digit selects) and the
//            decoded per-digit view produced by seg_scan_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_decoder_if #(
    parameter int NDIG = 8
);
    logic [7:0]        seg_n;
    logic [NDIG-1:0]   dig_n;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dots;
    logic [NDIG-1:0]   valid;
    logic              upd;
    logic              err;
    logic [7:0]        err_cnt;

    // Display driver side: owns the segment bus, observes decoded results.
    modport master (
        output seg_n, dig_n,
        input  value, dots, valid, upd, err, err_cnt
    );

    // Decoder side: samples the segment bus, publishes decoded results.
    modport slave (
        input  seg_n, dig_n,
        output value, dots, valid, upd, err, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Samples a multiplexed active-low seven-segment bus, waits for a
//            stable pattern and decodes it into a per-digit hex value + dot.
//            Optional error counter enabled by macro SEGDEC_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
    parameter int NDIG       = 8,
    parameter int STABLE_CYC = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seg_scan_decoder_if.slave   bus
);

    localparam int         SAMP_W     = 8 + NDIG;
    localparam logic [7:0] C_LAST_CNT = 8'(STABLE_CYC - 1);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Returns {legal, code} for an active-high a..g pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0_0000;
        case (s)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1110011: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b0001101: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1101111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [SAMP_W-1:0] samp_q;
    logic [7:0]        cnt_q,   cnt_d;
    state_t            state_q, state_d;
    logic              upd_q;
    logic              err_q;

    logic [SAMP_W-1:0] w_raw;
    logic              w_diff;
    logic              w_cap;
    logic [7:0]        w_seg;
    logic [NDIG-1:0]   w_sel;
    logic              w_any;
    logic              w_multi;
    logic [6:0]        w_s;
    logic [4:0]        w_dec;
    logic              w_legal;
    logic              w_blank;
    logic              w_upd_d;
    logic              w_err_d;

    assign w_raw  = {bus.seg_n, bus.dig_n};
    // The incoming sample is compared against the one already held, so a
    // change restarts the count on the same edge that first sees it.
    assign w_diff = (w_raw != samp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '1;
        end else begin
            samp_q <= w_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_cap   = 1'b0;
        if (w_diff) begin
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == C_LAST_CNT) begin
                        w_cap   = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // At capture the held sample equals the live bus, so decode from samp_q.
    assign w_seg   = samp_q[SAMP_W-1 -: 8];
    assign w_sel   = ~samp_q[NDIG-1:0];
    assign w_any   = |w_sel;
    assign w_multi = |(w_sel & (w_sel - NDIG'(1)));
    assign w_s     = ~w_seg[7:1];
    assign w_dec   = f_decode(w_s);
    assign w_legal = w_dec[4];
    assign w_blank = (w_s == 7'b000_0000);

    assign w_upd_d = w_cap && w_any && !w_multi;
    assign w_err_d = w_cap && w_any && (w_multi || (!w_legal && !w_blank));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            upd_q <= w_upd_d;
            err_q <= w_err_d;
        end
    end

    generate
        for (genvar d = 0; d < NDIG; d++) begin : g_dig
            logic [3:0] val_q;
            logic       dot_q;
            logic       vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_q <= 4'h0;
                    dot_q <= 1'b0;
                    vld_q <= 1'b0;
                end else if (w_upd_d && w_sel[d]) begin
                    dot_q <= ~w_seg[0];
                    vld_q <= w_legal;
                    // An illegal glyph leaves the last good value in place.
                    if (w_legal) begin
                        val_q <= w_dec[3:0];
                    end else if (w_blank) begin
                        val_q <= 4'h0;
                    end
                end
            end

            assign bus.value[4*d +: 4] = val_q;
            assign bus.dots[d]         = dot_q;
            assign bus.valid[d]        = vld_q;
        end
    endgenerate

`ifdef SEGDEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (w_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.upd = upd_q;
    assign bus.err = err_q;

endmodule

`default_nettype wire
